// File: rtl/serial_adder.sv
// serial_adder -- bit-serial ripple adder.
//
// Captures two WIDTH-bit operands and a carry-in on an accepted start, then
// adds one bit per clock (LSB first) through a single full-adder cell with a
// registered carry. After WIDTH add cycles the WIDTH-bit sum and the carry-out
// are registered and a one-cycle done pulse is raised. {cout,sum} equals
// a + b + cin.
//
// Parameters:
//   WIDTH   operand/sum width in bits, 2..32 (default 8)
//
// Ports:
//   clk    in   1      clock, all state updates on posedge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, sampled only in IDLE or DONE
//   a      in   WIDTH  operand A, captured on the accepted start
//   b      in   WIDTH  operand B, captured on the accepted start
//   cin    in   1      carry-in, captured on the accepted start
//   busy   out  1      high while adding (RUN)
//   done   out  1      one-cycle pulse, result valid
//   sum    out  WIDTH  registered result, held until next completion
//   cout   out  1      registered carry-out, held until next completion
//   ovf    out  1      signed overflow, registered with sum
//                      (present only when SERIAL_ADDER_OVF_EN is defined)
//
// Build option:
//   SERIAL_ADDER_OVF_EN  adds the ovf output and its register.

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    // Partial sum keeps only the upper WIDTH-1 bits: the bit that would sit
    // in position 0 is always shifted out before use, so the final sum is
    // taken from acc_d (new bit prepended) on the completion edge instead.
    logic [WIDTH-2:0]   acc_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q;
`endif

    logic               bit_s;
    logic               carry_d;
    logic [WIDTH-1:0]   acc_d;

    // Single full-adder cell on the current LSBs.
    always_comb begin
        bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_d = (a_sh_q[0] & b_sh_q[0]) |
                  (a_sh_q[0] & carry_q)   |
                  (b_sh_q[0] & carry_q);
        acc_d   = {bit_s, acc_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    carry_q <= carry_d;
                    acc_q   <= acc_d[WIDTH-1:1];
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        sum_q   <= acc_d;
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB position.
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=4): reset behaviour, directed cases,
// mid-run start and reset, exhaustive back-to-back adds and randomized adds
// with random idle gaps, checked against a+b+cin computed arithmetically.

module tb_serial_adder;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: last completed result (held outputs).
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".sum"}, sum, exp_sum);
        check({tag, ".cout"}, cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, ".ovf"}, ovf, exp_ovf);
`endif
    endtask

    // Issues start now (accepted on the next edge), runs the add while
    // checking timing and held outputs, returns just after the done edge.
    // Calling it again immediately gives a back-to-back start.
    task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic cv, input bit mid_start);
        logic [W:0] total;
        int         st;
        a = av; b = bv; cin = cv; start = 1'b1;
        tick();
        // Operand changes during RUN must not matter.
        start = 1'b0;
        a = W'($urandom());
        b = W'($urandom());
        cin = 1'($urandom());
        for (int i = 0; i < int'(W); i++) begin
            check("run.busy", busy, 1);
            check("run.done", done, 0);
            check("run.sum_held", sum, exp_sum);
            check("run.cout_held", cout, exp_cout);
            if (mid_start && i == 1) begin
                start = 1'b1; a = 4'h7; b = 4'h7;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        total    = {1'b0, av} + {1'b0, bv} + (W+1)'(cv);
        exp_sum  = total[W-1:0];
        exp_cout = total[W];
        st = int'($signed(av)) + int'($signed(bv)) + int'(cv);
        exp_ovf  = (st > (2**(W-1) - 1)) || (st < -(2**(W-1)));
        check("fin.busy", busy, 0);
        check("fin.done", done, 1);
        check("fin.sum", sum, exp_sum);
        check("fin.cout", cout, exp_cout);
`ifdef SERIAL_ADDER_OVF_EN
        check("fin.ovf", ovf, exp_ovf);
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;

        // Reset, then idle with start low.
        tick(); check_quiet("rst0");
        tick(); check_quiet("rst1");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_quiet("idle");
        end

        // Directed cases.
        do_add(4'h3, 4'h5, 1'b0, 1'b0);
        check("d1.sum", sum, 4'h8);
        tick(); check_quiet("d1.after");
        do_add(4'hF, 4'h1, 1'b1, 1'b0);
        check("d2.sum", sum, 4'h1);
        check("d2.cout", cout, 1);
        tick(); check_quiet("d2.after");
        do_add(4'hF, 4'hF, 1'b1, 1'b0);
        check("d3.sum", sum, 4'hF);
        check("d3.cout", cout, 1);
        tick(); check_quiet("d3.after");

        // Start pulse mid-run is ignored: one done, first result kept.
        do_add(4'h2, 4'h3, 1'b0, 1'b1);
        check("mid.sum", sum, 4'h5);
        tick(); check_quiet("mid.after");
        tick(); check_quiet("mid.after2");

        // Reset two cycles into RUN aborts the add.
        a = 4'h3; b = 4'h3; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        check_quiet("abort");
        for (int i = 0; i < 6; i++) begin
            tick(); check_quiet("abort.idle");
        end
        do_add(4'h1, 4'h2, 1'b0, 1'b0);
        check("abort.next_sum", sum, 4'h3);
        tick(); check_quiet("abort.after");

        // Exhaustive operands, back-to-back.
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    do_add(W'(ai), W'(bi), 1'(ci), 1'b0);
        tick(); check_quiet("b2b.after");

        // Randomized adds with random idle gaps (0 = back-to-back).
        for (int n = 0; n < 200; n++) begin
            int gap;
            gap = int'($urandom_range(2, 0));
            for (int g = 0; g < gap; g++) begin
                tick(); check_quiet("rnd.gap");
            end
            do_add(W'($urandom()), W'($urandom()), 1'($urandom()), 1'($urandom()));
        end
        tick(); check_quiet("rnd.after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
